// File: rtl/sdpram_arb.sv
// Two-requester round-robin arbiter/sequencer for a single-clock sdpram (read-first).
// Define SDPRAM_ARB_FWD_EN to forward same-cycle write data to a colliding read.
module sdpram_arb #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 10
) (
    input  logic             I_wclk,
    input  logic             I_rst,
    input  logic             I_wreq0,
    input  logic             I_wreq1,
    input  logic [ASIZE-1:0] I_waddr0,
    input  logic [ASIZE-1:0] I_waddr1,
    input  logic [DSIZE-1:0] I_wdata0,
    input  logic [DSIZE-1:0] I_wdata1,
    output logic             O_wgnt0,
    output logic             O_wgnt1,
    input  logic             I_rreq0,
    input  logic             I_rreq1,
    input  logic [ASIZE-1:0] I_raddr0,
    input  logic [ASIZE-1:0] I_raddr1,
    output logic             O_rgnt0,
    output logic             O_rgnt1,
    output logic             O_rvld0,
    output logic             O_rvld1,
    output logic [DSIZE-1:0] O_rdata0,
    output logic [DSIZE-1:0] O_rdata1,
    output logic             O_ram_ce,
    output logic             O_ram_wr,
    output logic [ASIZE-1:0] O_ram_waddr,
    output logic [DSIZE-1:0] O_ram_wdata,
    output logic             O_ram_rd,
    output logic [ASIZE-1:0] O_ram_raddr,
    input  logic [DSIZE-1:0] I_ram_rdata
);

    logic             wlast_q, wlast_d;
    logic             rlast_q, rlast_d;
    logic             ram_wr_q, ram_wr_d;
    logic [ASIZE-1:0] ram_waddr_q, ram_waddr_d;
    logic [DSIZE-1:0] ram_wdata_q, ram_wdata_d;
    logic             ram_rd_q, ram_rd_d;
    logic [ASIZE-1:0] ram_raddr_q, ram_raddr_d;
    logic             tag_p1_q, tag_p1_d;
    logic             rvld_p2_q, rvld_p2_d;
    logic             tag_p2_q, tag_p2_d;
    logic [DSIZE-1:0] ret_data;

    // With both requesting, the requester that did not win last time is granted.
    always_comb begin
        O_wgnt0 = ~I_rst & I_wreq0 & (~I_wreq1 | wlast_q);
        O_wgnt1 = ~I_rst & I_wreq1 & (~I_wreq0 | ~wlast_q);
        O_rgnt0 = ~I_rst & I_rreq0 & (~I_rreq1 | rlast_q);
        O_rgnt1 = ~I_rst & I_rreq1 & (~I_rreq0 | ~rlast_q);
    end

    always_comb begin
        wlast_d     = wlast_q;
        rlast_d     = rlast_q;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        ram_raddr_d = ram_raddr_q;
        tag_p1_d    = tag_p1_q;
        ram_wr_d    = O_wgnt0 | O_wgnt1;
        ram_rd_d    = O_rgnt0 | O_rgnt1;
        if (O_wgnt0 | O_wgnt1) begin
            wlast_d     = O_wgnt1;
            ram_waddr_d = O_wgnt1 ? I_waddr1 : I_waddr0;
            ram_wdata_d = O_wgnt1 ? I_wdata1 : I_wdata0;
        end
        if (O_rgnt0 | O_rgnt1) begin
            rlast_d     = O_rgnt1;
            ram_raddr_d = O_rgnt1 ? I_raddr1 : I_raddr0;
            tag_p1_d    = O_rgnt1;
        end
        rvld_p2_d = ram_rd_q;
        tag_p2_d  = tag_p1_q;
    end

    always_ff @(posedge I_wclk) begin
        if (I_rst) begin
            wlast_q     <= 1'b1;
            rlast_q     <= 1'b1;
            ram_wr_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            ram_rd_q    <= 1'b0;
            ram_raddr_q <= '0;
            tag_p1_q    <= 1'b0;
            rvld_p2_q   <= 1'b0;
            tag_p2_q    <= 1'b0;
        end else begin
            wlast_q     <= wlast_d;
            rlast_q     <= rlast_d;
            ram_wr_q    <= ram_wr_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rd_q    <= ram_rd_d;
            ram_raddr_q <= ram_raddr_d;
            tag_p1_q    <= tag_p1_d;
            rvld_p2_q   <= rvld_p2_d;
            tag_p2_q    <= tag_p2_d;
        end
    end

    // Strobes are squashed while reset is held so nothing in flight reaches the RAM.
    assign O_ram_wr    = ram_wr_q & ~I_rst;
    assign O_ram_rd    = ram_rd_q & ~I_rst;
    assign O_ram_ce    = O_ram_wr | O_ram_rd;
    assign O_ram_waddr = ram_waddr_q;
    assign O_ram_wdata = ram_wdata_q;
    assign O_ram_raddr = ram_raddr_q;

`ifdef SDPRAM_ARB_FWD_EN
    logic             fwd_q, fwd_d;
    logic [DSIZE-1:0] fwd_data_q, fwd_data_d;

    // RAM is read-first, so a same-address write in the issue cycle is replayed here.
    always_comb begin
        fwd_d      = O_ram_wr & O_ram_rd & (ram_waddr_q == ram_raddr_q);
        fwd_data_d = ram_wdata_q;
    end

    always_ff @(posedge I_wclk) begin
        if (I_rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign ret_data = fwd_q ? fwd_data_q : I_ram_rdata;
`else
    assign ret_data = I_ram_rdata;
`endif

    assign O_rvld0  = rvld_p2_q & ~tag_p2_q & ~I_rst;
    assign O_rvld1  = rvld_p2_q & tag_p2_q & ~I_rst;
    assign O_rdata0 = O_rvld0 ? ret_data : '0;
    assign O_rdata1 = O_rvld1 ? ret_data : '0;

endmodule
